// File: rtl/sigmoid_pwl_pipe.sv
// sigmoid_pwl_pipe
//   Three-stage pipelined fixed-point sigmoid using the PLAN piecewise-linear
//   approximation (shift-add only). Valid/ready handshakes on both sides; the
//   whole pipeline advances together whenever the output register is empty or
//   being drained.
//
//   Parameters
//     DATA_W : input/output width (DATA_W-FRAC_W >= 4)
//     FRAC_W : fractional bits (>= 5); input signed Q(DATA_W-FRAC_W).FRAC_W,
//              output unsigned with FRAC_W fractional bits, 1.0 = 2^FRAC_W
//
//   Ports
//     clk        rising-edge clock
//     reset_n    synchronous active-low reset
//     in_valid   input sample valid
//     in_ready   pipeline can accept a sample this cycle
//     in_data    signed fixed-point x
//     out_valid  output sample valid
//     out_ready  downstream accepts the output
//     out_data   unsigned fixed-point y in [0, 1.0]
//     sat_count  (SIGMOID_SAT_CNT_EN only) count of accepted samples with
//                |x| >= 5.0, saturating at 0xFFFF
//
//   Build option: define SIGMOID_SAT_CNT_EN to add the sat_count port.
module sigmoid_pwl_pipe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef SIGMOID_SAT_CNT_EN
  ,
  output logic [15:0]       sat_count
`endif
);

  typedef enum logic [1:0] {
    SEG0 = 2'd0,  // a < 1.0
    SEG1 = 2'd1,  // 1.0   <= a < 2.375
    SEG2 = 2'd2,  // 2.375 <= a < 5.0
    SEG3 = 2'd3   // a >= 5.0
  } seg_e;

  // Fixed-point constants, all expressed as exact integer multiples of 2^-5
  // or coarser so they hold for any FRAC_W >= 5.
  localparam logic [DATA_W-1:0] K_ONE    = DATA_W'(1)  << FRAC_W;
  localparam logic [DATA_W-1:0] K_2P375  = DATA_W'(19) << (FRAC_W - 3);
  localparam logic [DATA_W-1:0] K_5P0    = DATA_W'(5)  << FRAC_W;
  localparam logic [DATA_W-1:0] K_0P5    = DATA_W'(1)  << (FRAC_W - 1);
  localparam logic [DATA_W-1:0] K_0P625  = DATA_W'(5)  << (FRAC_W - 3);
  localparam logic [DATA_W-1:0] K_0P8438 = DATA_W'(27) << (FRAC_W - 5);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};

  logic adv;

  // Stage 1 registers: sign, magnitude, segment
  logic              s1_valid_q;
  logic              s1_sgn_q,  s1_sgn_d;
  logic [DATA_W-1:0] s1_a_q,    s1_a_d;
  seg_e              s1_seg_q,  s1_seg_d;

  // Stage 2 registers: sign, positive-half value
  logic              s2_valid_q;
  logic              s2_sgn_q;
  logic [DATA_W-1:0] s2_yp_q,   s2_yp_d;

  // Stage 3 registers: output
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  assign adv       = ~out_valid_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Stage 1: magnitude and segment select
  always_comb begin
    s1_sgn_d = in_data[DATA_W-1];
    if (!s1_sgn_d) begin
      s1_a_d = in_data;
    end else if (in_data == MOST_NEG) begin
      // -2^(DATA_W-1) has no positive counterpart; clamp to the largest code.
      s1_a_d = MAX_POS;
    end else begin
      s1_a_d = -in_data;
    end

    if (s1_a_d >= K_5P0) begin
      s1_seg_d = SEG3;
    end else if (s1_a_d >= K_2P375) begin
      s1_seg_d = SEG2;
    end else if (s1_a_d >= K_ONE) begin
      s1_seg_d = SEG1;
    end else begin
      s1_seg_d = SEG0;
    end
  end

  // Stage 2: positive-half line segment
  always_comb begin
    unique case (s1_seg_q)
      SEG0:    s2_yp_d = (s1_a_q >> 2) + K_0P5;
      SEG1:    s2_yp_d = (s1_a_q >> 3) + K_0P625;
      SEG2:    s2_yp_d = (s1_a_q >> 5) + K_0P8438;
      default: s2_yp_d = K_ONE;
    endcase
  end

  // Stage 3: mirror for negative inputs and clamp to [0, 1.0]
  always_comb begin
    if (s2_sgn_q) begin
      out_data_d = (s2_yp_q > K_ONE) ? '0 : (K_ONE - s2_yp_q);
    end else begin
      out_data_d = (s2_yp_q > K_ONE) ? K_ONE : s2_yp_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_sgn_q    <= 1'b0;
      s1_a_q      <= '0;
      s1_seg_q    <= SEG0;
      s2_valid_q  <= 1'b0;
      s2_sgn_q    <= 1'b0;
      s2_yp_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (adv) begin
      s1_valid_q  <= in_valid;
      s1_sgn_q    <= s1_sgn_d;
      s1_a_q      <= s1_a_d;
      s1_seg_q    <= s1_seg_d;
      s2_valid_q  <= s1_valid_q;
      s2_sgn_q    <= s1_sgn_q;
      s2_yp_q     <= s2_yp_d;
      out_valid_q <= s2_valid_q;
      out_data_q  <= out_data_d;
    end
  end

`ifdef SIGMOID_SAT_CNT_EN
  logic [15:0] sat_count_q;

  // Counted as the sample enters stage 1; a stalled sample is not accepted
  // yet, so it cannot be counted twice.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sat_count_q <= '0;
    end else if (adv && in_valid && (s1_seg_d == SEG3) && (sat_count_q != '1)) begin
      sat_count_q <= sat_count_q + 16'd1;
    end
  end

  assign sat_count = sat_count_q;
`endif

endmodule

// File: tb/tb_sigmoid_pwl_pipe.sv
// Self-checking bench for sigmoid_pwl_pipe (DATA_W=16, FRAC_W=12).
// Stimulus pushes expected results into a scoreboard queue on every input
// transfer; a monitor process pops and compares on every output transfer.
module tb_sigmoid_pwl_pipe;

  localparam int DW = 16;
  localparam int FW = 12;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
`ifdef SIGMOID_SAT_CNT_EN
  logic [15:0]   sat_count;
`endif

  sigmoid_pwl_pipe #(
    .DATA_W (DW),
    .FRAC_W (FW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SIGMOID_SAT_CNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    longint y;
    int     cyc;
  } exp_t;

  exp_t   sbq[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  bit     lat_chk = 1'b0;
  longint exp_sat = 0;
  bit     hold_prev = 1'b0;
  logic [DW-1:0] hold_data = '0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint mag(input logic [DW-1:0] x);
    longint xs;
    longint a;
    xs = $signed(x);
    a  = (xs < 0) ? -xs : xs;
    if (a > (longint'(1) << (DW - 1)) - 1) a = (longint'(1) << (DW - 1)) - 1;
    return a;
  endfunction

  // Reference sigmoid: plain integer arithmetic on the real-valued breakpoints.
  function automatic longint ref_sig(input logic [DW-1:0] x);
    longint one;
    longint a;
    longint yp;
    longint y;
    one = longint'(1) << FW;
    a   = mag(x);
    if (a >= 5 * one)            yp = one;
    else if (8 * a >= 19 * one)  yp = a / 32 + (27 * one) / 32;
    else if (a >= one)           yp = a / 8 + (5 * one) / 8;
    else                         yp = a / 4 + one / 2;
    y = x[DW-1] ? one - yp : yp;
    if (y < 0)   y = 0;
    if (y > one) y = one;
    return y;
  endfunction

  // Monitor: invariants, output scoreboard, then input capture.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
`ifdef SIGMOID_SAT_CNT_EN
      check("sat_count", sat_count, exp_sat);
`endif
      check("in_ready", in_ready, (!out_valid || out_ready) ? 1 : 0);
      if (hold_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_data);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          total = total + 1;
          bad = bad + 1;
          $display("FAIL unexpected_out: got %0d expected no output (t=%0t)", out_data, $time);
        end else begin
          e = sbq.pop_front();
          check("out_data", out_data, e.y);
          if (lat_chk) check("latency", cyc - e.cyc, 3);
        end
      end
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
      if (in_valid && in_ready) begin
        sbq.push_back('{ref_sig(in_data), cyc});
        if (mag(in_data) >= 5 * (longint'(1) << FW) && exp_sat < 65535) exp_sat = exp_sat + 1;
      end
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Offer samples in order, holding each until accepted; out_ready is low
  // during cycles [st, st+sl).
  task automatic drive(input int xs[$], input int st, input int sl);
    int idx;
    int c;
    bit took;
    idx = 0;
    c = 0;
    in_valid = 1'b1;
    in_data = DW'(xs[0]);
    while (idx < xs.size()) begin
      out_ready = !(c >= st && c < st + sl);
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (took) idx = idx + 1;
      if (idx < xs.size()) in_data = DW'(xs[idx]);
      else in_valid = 1'b0;
      c = c + 1;
      if (c > 200) begin
        check("drive_timeout", idx, xs.size());
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sbq.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n = n + 1;
    end
    check("drain_left", sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    int q[$];
    int specials[$];
    bit took;

    // Reset
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef SIGMOID_SAT_CNT_EN
    check("rst_sat_count", sat_count, 0);
`endif

    // Positive stream, negatives and boundaries without stalls
    lat_chk = 1'b1;
    q = '{0, 2048, 4096, 12288, 24576};
    drive(q, -1, 0);
    drain();
    q = '{-4096, -12288, -24576, -32768};
    drive(q, -1, 0);
    drain();
    q = '{9728, 9727, 20480, 20479};
    drive(q, -1, 0);
    drain();
    lat_chk = 1'b0;

    // Backpressure mid-stream
    q = '{1000, -1000, 5000, -9000, 30000, -20000};
    drive(q, 4, 4);
    drain();

    // Reset with three samples in flight
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = DW'(24576);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset_n = 1'b0;
    sbq.delete();
    exp_sat = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
`ifdef SIGMOID_SAT_CNT_EN
    check("flush_sat_count", sat_count, 0);
`endif
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("flush_quiet", out_valid, 0);

    // Saturation counting with the fourth sample stalled for 3 cycles
    q = '{24576, -24576, 4096, 20480};
    drive(q, 0, 6);
    drain();
`ifdef SIGMOID_SAT_CNT_EN
    check("sat_count_final", sat_count, 3);
`endif

    // Randomized traffic
    specials = '{0, -1, 1, 4095, 4096, -4096, 9727, 9728, -9728, 20479,
                 20480, -20480, 32767, -32768, 2048, -2048};
    took = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 3) == 0)
          in_data = DW'(specials[$urandom_range(0, specials.size() - 1)]);
        else
          in_data = DW'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sigmoid_pwl_pipe.md
Name: sigmoid_pwl_pipe

Overview:
- Parametrised fixed-point successor to the combinational sigmoid block.
- Computes y = sigmoid(x) with the PLAN piecewise-linear approximation, using shift-add only (no multipliers or exponent).
- 3-stage pipeline with valid/ready handshakes on both sides.
- Sits between a neuron's accumulator output and the next layer's input buffer.

Parameters:
- DATA_W, 16: total input/output width. Constraint: DATA_W-FRAC_W >= 4.
- FRAC_W, 12: fractional bits. Input is signed Q(DATA_W-FRAC_W).FRAC_W; output is unsigned with the same FRAC_W. Constraint: FRAC_W >= 5.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  DATA_W  signed fixed-point x.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output.
- out_data  out  DATA_W  unsigned fixed-point y, range 0 to 1.0 (1.0 = 2^FRAC_W).
- sat_count  out  16  only present with SIGMOID_SAT_CNT_EN.

Behaviour:
- Reset (reset_n=0 sampled at clk edge): all stage valids = 0, out_valid=0, out_data=0, sat_count=0. in_ready=1 in the cycle after reset.
- Reset mid-operation flushes in-flight samples; none are emitted.
- Advance enable: adv = ~out_valid | out_ready. in_ready = adv, purely combinational from out_valid/out_ready.
- Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
- When adv=0, all stages hold; out_data is stable while out_valid=1 and out_ready=0.
- Pipeline bubbles propagate as valid=0. Throughput is 1 sample/cycle. Latency is 3 cycles from input transfer to out_valid, with no stall.
- Stage 1:
  - sgn = in_data[MSB]; a = |in_data|.
  - Most negative code (-2^(DATA_W-1)): a saturates to 2^(DATA_W-1)-1.
  - Segment select on a, using >= at each boundary (constants K = value·2^FRAC_W):
    - S3: a >= 5.0
    - S2: 2.375 <= a < 5.0
    - S1: 1.0 <= a < 2.375
    - S0: a < 1.0
- Stage 2: yp = positive-half value, width DATA_W, shifts are logical right and truncate.
  - S0: (a>>2) + 0.5
  - S1: (a>>3) + 0.625
  - S2: (a>>5) + 0.84375
  - S3: 1.0
- Stage 3:
  - y = sgn ? (1.0 - yp) : yp.
  - Clamp to [0, 1.0].
  - Register into out_data.
- x=0 is treated as positive (y=0.5). Output never exceeds 2^FRAC_W.
- Simultaneous in and out transfer in the same cycle is legal and keeps the pipeline full.

Optional Feature:
- Macro: SIGMOID_SAT_CNT_EN.
- Defined:
  - sat_count port exists; it increments on each input transfer whose segment is S3.
  - It saturates at 0xFFFF (no wrap) and resets to 0.
  - The count is taken at stage 1 when the stage advances, so stalled samples are not double counted.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan (DATA_W=16, FRAC_W=12):
- After reset, streaming x = 0, 2048 (0.5), 4096 (1.0), 12288 (3.0), 24576 (6.0) with out_ready=1 -> out_data = 2048, 2560, 3072, 3840, 4096. Each appears 3 cycles after its input; out_valid stays high for 5 consecutive cycles.
- Negatives x = -4096, -12288, -24576, -32768 -> out_data = 1024, 256, 0, 0. No overflow on -32768.
- Boundaries x = 9728 (2.375), 9727, 20480 (5.0), 20479 -> 3760, 3775, 4096, 4095 (S2/S1/S3/S2 per >= rule).
- Backpressure: stream 6 samples, drop out_ready for 4 cycles mid-stream -> in_ready=0 while out_valid&~out_ready, out_data held stable, no sample lost or duplicated, order preserved.
- Assert reset_n=0 for 1 cycle with 3 samples in flight -> out_valid=0 the next cycle, nothing emitted until new input; sat_count=0.
- With SIGMOID_SAT_CNT_EN: inputs 24576, -24576, 4096, and 20480 held under a 3-cycle stall -> sat_count=3.
